// File: rtl/pong_engine.sv
// pong_engine: frame-rate pong game state (paddles, ball, serve/score FSM, beep requests).
// Ports:
//   i_clk, i_rst_n          clock and asynchronous active-low reset
//   i_frame_tick            one-cycle pulse per frame; all state advances only on it
//   i_p{1,2}_{up,dn,srv}    player buttons, already synchronised
//   o_p1_y, o_p2_y          paddle top y
//   o_ball_x, o_ball_y      ball top-left corner
//   o_score1, o_score2      player scores
//   o_state                 0 SERVE_L, 1 SERVE_R, 2 PLAY, 3 OVER
//   o_beep_low, o_beep_high tone requests, never both high
// Option: define PONG_AI_EN to make player 2 track the ball and serve by itself.
module pong_engine #(
    parameter int SCREEN_H    = 480,
    parameter int PAD_H       = 50,
    parameter int PAD_W       = 8,
    parameter int BALL_SZ     = 8,
    parameter int P1_X        = 40,
    parameter int P2_X        = 600,
    parameter int P_SPD       = 16,
    parameter int BX_SPD      = 8,
    parameter int BY_SPD      = 8,
    parameter int MAX_SCORE   = 9,
    parameter int SCORE_W     = 4,
    parameter int BEEP_FRAMES = 6
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_frame_tick,
    input  logic               i_p1_up,
    input  logic               i_p1_dn,
    input  logic               i_p1_srv,
    input  logic               i_p2_up,
    input  logic               i_p2_dn,
    input  logic               i_p2_srv,
    output logic [8:0]         o_p1_y,
    output logic [8:0]         o_p2_y,
    output logic [9:0]         o_ball_x,
    output logic [8:0]         o_ball_y,
    output logic [SCORE_W-1:0] o_score1,
    output logic [SCORE_W-1:0] o_score2,
    output logic [1:0]         o_state,
    output logic               o_beep_low,
    output logic               o_beep_high
);
    typedef enum logic [1:0] {SERVE_L, SERVE_R, PLAY, OVER} state_t;

    localparam int BW = $clog2(BEEP_FRAMES + 1);
    localparam logic signed [10:0] K_YMAX = 11'(SCREEN_H - PAD_H);
    localparam logic signed [10:0] K_BMAX = 11'(SCREEN_H - BALL_SZ);
    localparam logic signed [10:0] K_LX   = 11'(P1_X + PAD_W);
    localparam logic signed [10:0] K_RX   = 11'(P2_X - BALL_SZ);
    localparam logic signed [10:0] K_MR   = 11'(P2_X + PAD_W);
    localparam logic signed [10:0] K_PS   = 11'(P_SPD);
    localparam logic signed [10:0] K_BX   = 11'(BX_SPD);
    localparam logic signed [10:0] K_BY   = 11'(BY_SPD);
    localparam logic signed [10:0] K_PH   = 11'(PAD_H);
    localparam logic signed [10:0] K_BS   = 11'(BALL_SZ);
    localparam logic signed [10:0] K_OFS  = 11'(PAD_H / 2 - BALL_SZ / 2);
    localparam logic [8:0]         K_P0   = 9'((SCREEN_H - PAD_H) / 2);
    localparam logic [8:0]         K_BY0  = 9'((SCREEN_H - PAD_H) / 2 + PAD_H / 2 - BALL_SZ / 2);

    state_t                r_state, w_next;
    logic [8:0]            r_p1_y, r_p2_y, r_by;
    logic [9:0]            r_bx;
    logic signed [10:0]    r_vx, r_vy;
    logic [SCORE_W-1:0]    r_s1, r_s2, w_s1_inc, w_s2_inc;
    logic [BW-1:0]         r_bcnt;
    logic                  r_btone, r_armed;

    logic                  w_tick, w_play, w_wall, w_hit1, w_hit2, w_miss_l, w_miss_r, w_live;
    logic                  w_srv2, w_srv_any, w_up2, w_dn2, w_park_l, w_unused;
    logic signed [10:0]    w_p1, w_p2, w_bx, w_by, w_nx, w_ny_raw, w_ny, w_nx_hit, w_park_y;

    // Paddle step with clamping to the playfield; opposing buttons cancel.
    function automatic logic [8:0] f_move(input logic signed [10:0] y, input logic up, input logic dn);
        logic signed [10:0] t;
        t = (up && !dn) ? y - K_PS : (dn && !up) ? y + K_PS : y;
        return (t < 0) ? 9'd0 : (t > K_YMAX) ? K_YMAX[8:0] : t[8:0];
    endfunction

    // The first edge after reset release is never a game step, even if a tick is present.
    assign w_tick   = i_frame_tick & r_armed;
    assign w_play   = r_state == PLAY;
    assign w_p1     = $signed({2'b00, r_p1_y});
    assign w_p2     = $signed({2'b00, r_p2_y});
    assign w_bx     = $signed({1'b0, r_bx});
    assign w_by     = $signed({2'b00, r_by});
    assign w_nx     = w_bx + r_vx;
    assign w_ny_raw = w_by + r_vy;
    assign w_wall   = w_play && ((w_ny_raw <= 0) || (w_ny_raw >= K_BMAX));
    assign w_ny     = (w_ny_raw <= 0) ? 11'sd0 : (w_ny_raw >= K_BMAX) ? K_BMAX : w_ny_raw;
    // Paddle hits only count when the ball crosses the paddle face this frame.
    assign w_hit1   = w_play && (r_vx < 0) && (w_nx <= K_LX) && (w_bx >= K_LX) &&
                      (w_ny + K_BS > w_p1) && (w_ny < w_p1 + K_PH);
    assign w_hit2   = w_play && (r_vx > 0) && (w_nx >= K_RX) && (w_bx <= K_RX) &&
                      (w_ny + K_BS > w_p2) && (w_ny < w_p2 + K_PH);
    assign w_miss_l = w_play && !w_hit1 && (w_nx < 0);
    assign w_miss_r = w_play && (w_nx > K_MR);
    assign w_live   = w_play && !w_miss_l && !w_miss_r;
    assign w_nx_hit = w_hit1 ? K_LX : w_hit2 ? K_RX : w_nx;
    assign w_s1_inc = r_s1 + 1'b1;
    assign w_s2_inc = r_s2 + 1'b1;
    // Ball is parked at the serving paddle of the state being entered (or held).
    assign w_park_l = w_play ? (w_next == SERVE_L) : (r_state == SERVE_L);
    assign w_park_y = (w_park_l ? w_p1 : w_p2) + K_OFS;
    assign w_unused = ^{w_ny[10:9], w_nx_hit[10], w_park_y[10:9]};

`ifdef PONG_AI_EN
    logic [5:0]         r_ai_cnt;
    logic               w_unused_p2;
    logic signed [10:0] w_p2c, w_bc;
    assign w_unused_p2 = ^{i_p2_up, i_p2_dn, i_p2_srv};
    assign w_p2c       = w_p2 + 11'(PAD_H / 2);
    assign w_bc        = w_by + 11'(BALL_SZ / 2);
    assign w_up2       = w_p2c > w_bc + 11'sd4;
    assign w_dn2       = w_p2c < w_bc - 11'sd4;
    // r_ai_cnt holds ticks already spent in SERVE_R, so 59 marks the 60th tick.
    assign w_srv2      = (r_state == SERVE_R) && (r_ai_cnt == 6'd59);
    assign w_srv_any   = i_p1_srv;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_ai_cnt <= '0;
        else if (w_tick) r_ai_cnt <= (r_state == SERVE_R) ? r_ai_cnt + 1'b1 : 6'd0;
    end
`else
    assign w_up2     = i_p2_up;
    assign w_dn2     = i_p2_dn;
    assign w_srv2    = i_p2_srv;
    assign w_srv_any = i_p1_srv | i_p2_srv;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= SERVE_R;
        else if (w_tick) r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            SERVE_L: w_next = i_p1_srv ? PLAY : SERVE_L;
            SERVE_R: w_next = w_srv2 ? PLAY : SERVE_R;
            PLAY:    w_next = w_miss_l ? ((w_s2_inc == SCORE_W'(MAX_SCORE)) ? OVER : SERVE_L) :
                              w_miss_r ? ((w_s1_inc == SCORE_W'(MAX_SCORE)) ? OVER : SERVE_R) : PLAY;
            OVER:    w_next = w_srv_any ? SERVE_R : OVER;
            default: w_next = r_state;
        endcase
    end

    always_comb begin
        o_state     = r_state;
        o_beep_low  = (r_bcnt != '0) && !r_btone;
        o_beep_high = (r_bcnt != '0) && r_btone;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_armed <= 1'b0;
            r_p1_y  <= K_P0;
            r_p2_y  <= K_P0;
            r_bx    <= K_RX[9:0];
            r_by    <= K_BY0;
            r_vx    <= '0;
            r_vy    <= K_BY;
            r_s1    <= '0;
            r_s2    <= '0;
            r_bcnt  <= '0;
            r_btone <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            if (w_tick) begin
                r_p1_y <= f_move(w_p1, i_p1_up, i_p1_dn);
                r_p2_y <= f_move(w_p2, w_up2, w_dn2);
                r_bx   <= w_live ? w_nx_hit[9:0] : (w_park_l ? K_LX[9:0] : K_RX[9:0]);
                r_by   <= w_live ? w_ny[8:0] : w_park_y[8:0];
                r_vx   <= ((r_state == SERVE_L && w_next == PLAY) || w_hit1) ? K_BX :
                          ((r_state == SERVE_R && w_next == PLAY) || w_hit2) ? -K_BX : r_vx;
                if (w_wall) r_vy <= -r_vy;
                if (r_state == OVER && w_next == SERVE_R) begin
                    r_s1 <= '0;
                    r_s2 <= '0;
                end else begin
                    if (w_miss_r) r_s1 <= w_s1_inc;
                    if (w_miss_l) r_s2 <= w_s2_inc;
                end
                // A miss outranks bounces; any event restarts the tone timer.
                if (w_miss_l || w_miss_r || w_hit1 || w_hit2 || w_wall) begin
                    r_bcnt  <= BW'(BEEP_FRAMES);
                    r_btone <= w_miss_l || w_miss_r;
                end else if (r_bcnt != '0) begin
                    r_bcnt <= r_bcnt - 1'b1;
                end
            end
        end
    end

    assign o_p1_y   = r_p1_y;
    assign o_p2_y   = r_p2_y;
    assign o_ball_x = r_bx;
    assign o_ball_y = r_by;
    assign o_score1 = r_s1;
    assign o_score2 = r_s2;
endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine: checks pong_engine against a frame-level game model driven by directed and random play.
module tb_pong_engine;
    localparam int P_SPD  = 16;
    localparam int Y_MAX  = 430;
    localparam int B_MAX  = 472;
    localparam int L_EDGE = 48;
    localparam int R_EDGE = 592;
    localparam int R_MISS = 608;
    localparam int OFS    = 21;
    localparam int WIN    = 9;
    localparam int BEEPS  = 6;

    logic       clk = 0, rst_n = 0, tick = 0;
    logic       u1 = 0, d1 = 0, s1 = 0, u2 = 0, d2 = 0, s2 = 0;
    logic [8:0] p1_y, p2_y, ball_y;
    logic [9:0] ball_x;
    logic [3:0] sc1, sc2;
    logic [1:0] st;
    logic       bl, bh;

    int total = 0, bad = 0;
    int m_p1, m_p2, m_bx, m_by, m_vx, m_vy, m_s1, m_s2, m_st, m_cnt, m_tone, m_ai;

    always #5 clk = ~clk;

    pong_engine dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_tick(tick),
        .i_p1_up(u1), .i_p1_dn(d1), .i_p1_srv(s1),
        .i_p2_up(u2), .i_p2_dn(d2), .i_p2_srv(s2),
        .o_p1_y(p1_y), .o_p2_y(p2_y), .o_ball_x(ball_x), .o_ball_y(ball_y),
        .o_score1(sc1), .o_score2(sc2), .o_state(st),
        .o_beep_low(bl), .o_beep_high(bh)
    );

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        total++;
        assert (got === 32'(exp)) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string p);
        chk({p, ".p1_y"}, 32'(p1_y), m_p1);
        chk({p, ".p2_y"}, 32'(p2_y), m_p2);
        chk({p, ".ball_x"}, 32'(ball_x), m_bx);
        chk({p, ".ball_y"}, 32'(ball_y), m_by);
        chk({p, ".score1"}, 32'(sc1), m_s1);
        chk({p, ".score2"}, 32'(sc2), m_s2);
        chk({p, ".state"}, 32'(st), m_st);
        chk({p, ".beep_low"}, 32'(bl), (m_cnt > 0 && m_tone == 0) ? 1 : 0);
        chk({p, ".beep_high"}, 32'(bh), (m_cnt > 0 && m_tone == 1) ? 1 : 0);
    endtask

    function automatic int clampi(int v, int lo, int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    function automatic int dirv(bit up, bit dn);
        return (up && !dn) ? -P_SPD : (dn && !up) ? P_SPD : 0;
    endfunction

    // -1 move up, +1 move down, 0 hold: paddle centre against ball centre with a 4px deadband.
    function automatic int track(int py, int by);
        return (py + 25 > by + 8) ? -1 : (py + 25 < by) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_p1 = 215; m_p2 = 215; m_bx = R_EDGE; m_by = 236; m_vx = 0; m_vy = 8;
        m_s1 = 0; m_s2 = 0; m_st = 1; m_cnt = 0; m_tone = 0; m_ai = 0;
    endtask

    // One frame of the game rules, using the paddle positions from before this frame's move.
    task automatic step(input bit a1, input bit b1, input bit c1, input bit a2, input bit b2, input bit c2);
        int op1, op2, rx, ny, ns, dy2;
        bit wall, h1, h2, miss, srv2, anysrv;
        op1 = m_p1; op2 = m_p2; ns = m_st;
        wall = 0; h1 = 0; h2 = 0; miss = 0;
`ifdef PONG_AI_EN
        dy2 = track(op2, m_by) * P_SPD; srv2 = (m_ai == 59); anysrv = c1;
`else
        dy2 = dirv(a2, b2); srv2 = c2; anysrv = c1 || c2;
`endif
        if (m_st == 0) begin
            m_bx = L_EDGE; m_by = op1 + OFS;
            if (c1) begin ns = 2; m_vx = 8; end
        end else if (m_st == 1) begin
            m_bx = R_EDGE; m_by = op2 + OFS;
            if (srv2) begin ns = 2; m_vx = -8; end
        end else if (m_st == 3) begin
            m_bx = R_EDGE; m_by = op2 + OFS;
            if (anysrv) begin m_s1 = 0; m_s2 = 0; ns = 1; end
        end else begin
            rx = m_bx + m_vx; ny = m_by + m_vy;
            if (ny <= 0) begin ny = 0; wall = 1; end
            else if (ny >= B_MAX) begin ny = B_MAX; wall = 1; end
            h1 = m_vx < 0 && rx <= L_EDGE && m_bx >= L_EDGE && ny + 8 > op1 && ny < op1 + 50;
            h2 = m_vx > 0 && rx >= R_EDGE && m_bx <= R_EDGE && ny + 8 > op2 && ny < op2 + 50;
            if (wall) m_vy = -m_vy;
            if (!h1 && rx < 0) begin miss = 1; m_s2++; ns = (m_s2 == WIN) ? 3 : 0; end
            else if (rx > R_MISS) begin miss = 1; m_s1++; ns = (m_s1 == WIN) ? 3 : 1; end
            if (miss) begin
                m_bx = (ns == 0) ? L_EDGE : R_EDGE;
                m_by = ((ns == 0) ? op1 : op2) + OFS;
            end else begin
                m_bx = h1 ? L_EDGE : h2 ? R_EDGE : rx;
                m_by = ny;
                if (h1) m_vx = 8;
                if (h2) m_vx = -8;
            end
        end
        if (miss) begin m_cnt = BEEPS; m_tone = 1; end
        else if (h1 || h2 || wall) begin m_cnt = BEEPS; m_tone = 0; end
        else if (m_cnt > 0) m_cnt--;
        m_ai = (m_st == 1) ? m_ai + 1 : 0;
        m_p1 = clampi(op1 + dirv(a1, b1), 0, Y_MAX);
        m_p2 = clampi(op2 + dy2, 0, Y_MAX);
        m_st = ns;
    endtask

    task automatic do_tick(input bit a1, input bit b1, input bit c1, input bit a2, input bit b2, input bit c2);
        @(negedge clk);
        check_all("idle");
        {u1, d1, s1, u2, d2, s2} = {a1, b1, c1, a2, b2, c2};
        tick = 1;
        @(negedge clk);
        tick = 0;
        {u1, d1, s1, u2, d2, s2} = 6'($urandom);
        step(a1, b1, c1, a2, b2, c2);
        check_all("tick");
    endtask

    // anti=1 makes player 1 steer away from the ball; both players serve whenever it is their turn.
    task automatic play_tick(input bit anti);
        int t1, t2;
        t1 = track(m_p1, m_by);
        if (anti) t1 = (t1 == 0) ? -1 : -t1;
        t2 = track(m_p2, m_by);
        do_tick(t1 == -1, t1 == 1, m_st == 0, t2 == -1, t2 == 1, m_st == 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        tick = 1;
        #2 rst_n = 0;
        #1 model_reset();
        check_all("reset");
        repeat (2) @(negedge clk);
        check_all("in_reset");
        {u1, d1, s1, u2, d2, s2} = 6'h3f;
        rst_n = 1;
        @(negedge clk);
        tick = 0;
        check_all("release");
    endtask

    initial begin
        do_reset();
        repeat (3) do_tick(0, 0, 0, 0, 0, 0);
        repeat (20) do_tick(1, 0, 0, 0, 0, 0);
        chk("p1_clamped_top", 32'(p1_y), 0);
        repeat (2) do_tick(1, 1, 0, 0, 0, 0);
        repeat (3) do_tick(0, 1, 0, 0, 0, 0);
        do_tick(0, 0, 1, 0, 0, 0);
`ifndef PONG_AI_EN
        chk("p1_srv_ignored", 32'(st), 1);
        do_tick(0, 0, 0, 0, 0, 1);
        chk("served", 32'(st), 2);
`endif
        repeat (300) play_tick(0);
        repeat (300) do_tick(1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
                             1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
        for (int i = 0; i < 4000 && m_st != 3; i++) play_tick(1);
        chk("game_over", 32'(st), 3);
        chk("winner_score2", 32'(sc2), WIN);
        do_tick(0, 0, 1, 0, 0, 0);
        chk("over_cleared_state", 32'(st), 1);
        chk("over_cleared_score2", 32'(sc2), 0);
        for (int i = 0; i < 600 && !(m_cnt > 0 && m_cnt < BEEPS); i++) play_tick(0);
        do_reset();
        repeat (5) do_tick(0, 0, 0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
